// File: rtl/reg_file.sv
// Multi-ported register file: one synchronous write port, two combinational read ports.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic [ADDR_W-1:0] RADDR_A,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [WIDTH-1:0]  RDATA_A,
  output logic [WIDTH-1:0]  RDATA_B
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             write_en;

  // True for addresses that map onto a real, writable/readable storage entry.
  function automatic logic entry_live(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_W) && !((ZERO_R0 != 0) && (addr == '0));
  endfunction

  assign write_en = RST_N && WE && entry_live(WADDR);

  // NOTE: the array is cleared by reset because every entry must read zero after
  // the reset edge; this forces flops rather than a RAM macro.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment for all clocked state so reads in the same
        // edge see pre-edge values regardless of process ordering.
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[WADDR] <= WDATA;
    end
  end

  always_comb begin
    // NOTE: outputs get a default first so every path assigns them and no latch forms.
    RDATA_A = '0;
    RDATA_B = '0;
    if (entry_live(RADDR_A)) RDATA_A = mem[RADDR_A];
    if (entry_live(RADDR_B)) RDATA_B = mem[RADDR_B];
`ifdef REG_FILE_BYPASS_EN
    // write_en already excludes the zero entry and out-of-range addresses.
    if (write_en && (RADDR_A == WADDR)) RDATA_A = WDATA;
    if (write_en && (RADDR_B == WADDR)) RDATA_B = WDATA;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: two instances (8 entries with zero r0, 6 entries without)
// share stimulus; a reference model predicts read data and a monitor checks at negedge.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst_n, we;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] ra0, rb0, ra1, rb1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] a0, b0, a1, b1;
  } exp_t;

  exp_t sb[$];

  // Model contents: m0 for the 8-entry zero-r0 instance, m1 for the 6-entry instance.
  logic [7:0] m0 [8];
  logic [7:0] m1 [8];

  always #5 clk = ~clk;

  reg_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_R0(1)) dut0 (
    .CLK(clk), .RST_N(rst_n), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .RADDR_A(raddr_a), .RADDR_B(raddr_b), .RDATA_A(ra0), .RDATA_B(rb0)
  );

  reg_file #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .ZERO_R0(0)) dut1 (
    .CLK(clk), .RST_N(rst_n), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .RADDR_A(raddr_a), .RADDR_B(raddr_b), .RDATA_A(ra1), .RDATA_B(rb1)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Expected read value for one instance given its geometry and the current inputs.
  function automatic logic [7:0] model_read(input int depth, input bit zero_r0,
                                            input logic [7:0] m [8], input logic [2:0] a);
    if (int'(a) >= depth) return 8'h00;
    if (zero_r0 && a == 3'd0) return 8'h00;
`ifdef REG_FILE_BYPASS_EN
    if (rst_n && we && waddr == a) return wdata;
`endif
    return m[a];
  endfunction

  task automatic push_expect(input string nm);
    exp_t e;
    e.name = nm;
    e.a0 = model_read(8, 1'b1, m0, raddr_a);
    e.b0 = model_read(8, 1'b1, m0, raddr_b);
    e.a1 = model_read(6, 1'b0, m1, raddr_a);
    e.b1 = model_read(6, 1'b0, m1, raddr_b);
    sb.push_back(e);
  endtask

  task automatic model_edge(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wd);
    if (!r) begin
      for (int i = 0; i < 8; i++) begin
        m0[i] = 8'h00;
        m1[i] = 8'h00;
      end
    end else if (w) begin
      if (wa != 3'd0) m0[wa] = wd;
      if (int'(wa) < 6) m1[wa] = wd;
    end
  endtask

  // Drive one cycle of stimulus, optionally queue the expected reads, advance past the edge.
  task automatic step(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] a, input logic [2:0] b, input string nm, input bit chk);
    rst_n = r; we = w; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;
    if (chk) push_expect(nm);
    @(posedge clk);
    model_edge(r, w, wa, wd);
    #1;
  endtask

  // Monitor: the read ports are combinational, so each cycle's result is sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, "/d0_a"}, ra0, e.a0);
      check({e.name, "/d0_b"}, rb0, e.b0);
      check({e.name, "/d1_a"}, ra1, e.a1);
      check({e.name, "/d1_b"}, rb1, e.b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    #1;
    step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, "rst0", 1'b0);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 8'hA5, 3'(i), 3'(i), "fill_a5", 1'b1);
    step(1'b0, 1'b1, 3'd4, 8'h77, 3'd4, 3'd4, "rst_vs_wr", 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), "post_rst", 1'b1);

    step(1'b1, 1'b1, 3'd3, 8'h3C, 3'd0, 3'd1, "wr3", 1'b1);
    step(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd2, "rd3_rd2", 1'b1);

    step(1'b1, 1'b1, 3'd0, 8'hFF, 3'd1, 3'd1, "wr0", 1'b1);
    step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, "rd0", 1'b1);

    step(1'b1, 1'b1, 3'd5, 8'h11, 3'd2, 3'd2, "wr5_11", 1'b1);
    step(1'b1, 1'b1, 3'd5, 8'h22, 3'd5, 3'd5, "same_cycle5", 1'b1);
    step(1'b1, 1'b0, 3'd0, 8'h00, 3'd5, 3'd5, "after5", 1'b1);

    step(1'b1, 1'b1, 3'd7, 8'h99, 3'd7, 3'd6, "oor_wr7", 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'd0, 8'h00, 3'(i), 3'd7, "oor_scan", 1'b1);

    // Reset pulse between edges must not disturb stored state.
    rst_n = 1'b1; we = 1'b0; raddr_a = 3'd3; raddr_b = 3'd5;
    push_expect("rst_glitch");
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd5, "post_glitch", 1'b1);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random", 1'b1);
    end

    step(1'b1, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1, "final", 1'b1);
    repeat (2) @(posedge clk);
    check("sb_drain", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
